// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared types for the EX/MEM pipeline register slice.
// Optional macro EX_MEM_BRANCH_RESOLVE_EN adds a branch target field to each entry.
`default_nettype none

package ex_mem_pkg;

    localparam int DEF_N  = 64;
    localparam int DEF_RW = 5;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
        logic branch;
    } ex_mem_ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } ex_mem_state_t;

    // Field layout reference for the default widths; the datapath packs the same order.
    typedef struct packed {
        logic [DEF_N-1:0]  result;
        logic              zero;
        logic [DEF_N-1:0]  wr_data;
        logic [DEF_RW-1:0] rd;
        ex_mem_ctrl_t      ctrl;
`ifdef EX_MEM_BRANCH_RESOLVE_EN
        logic [DEF_N-1:0]  br_target;
`endif
    } ex_mem_entry_t;

    function automatic int entry_width(input int n, input int rw);
`ifdef EX_MEM_BRANCH_RESOLVE_EN
        return 3 * n + 1 + rw + $bits(ex_mem_ctrl_t);
`else
        return 2 * n + 1 + rw + $bits(ex_mem_ctrl_t);
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_mem_entry_reg.sv
// ex_mem_entry_reg: load-enabled entry register, cleared by asynchronous active-low reset.
`default_nettype none

module ex_mem_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: two-entry elastic EX/MEM pipeline register (main + skid) with flush.
// Optional macro EX_MEM_BRANCH_RESOLVE_EN adds br_target / out_pcsrc / out_br_target.
`default_nettype none

module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int N  = 64,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  alu_result,
    input  logic          alu_zero,
    input  logic [N-1:0]  wr_data,
    input  logic [RW-1:0] rd,
    input  ex_mem_ctrl_t  ctrl,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_result,
    output logic          out_zero,
    output logic [N-1:0]  out_wr_data,
    output logic [RW-1:0] out_rd,
    output ex_mem_ctrl_t  out_ctrl
`ifdef EX_MEM_BRANCH_RESOLVE_EN
   ,input  logic [N-1:0]  br_target,
    output logic          out_pcsrc,
    output logic [N-1:0]  out_br_target
`endif
);

    localparam int W = entry_width(N, RW);

    ex_mem_state_t state, state_nxt;
    logic [W-1:0]  in_entry, main_d, main_q, skid_q;
    logic          accept, emit;
    logic          main_load, skid_load, main_from_skid;

`ifdef EX_MEM_BRANCH_RESOLVE_EN
    assign in_entry = {alu_result, alu_zero, wr_data, rd, ctrl, br_target};
    assign {out_result, out_zero, out_wr_data, out_rd, out_ctrl, out_br_target} = main_q;
    assign out_pcsrc = out_valid & out_ctrl.branch & out_zero;
`else
    assign in_entry = {alu_result, alu_zero, wr_data, rd, ctrl};
    assign {out_result, out_zero, out_wr_data, out_rd, out_ctrl} = main_q;
`endif

    // Handshake flags come from state alone so out_ready never reaches in_ready.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !emit) begin
                        state_nxt = FULL;
                        skid_load = 1'b1;
                    end else if (accept && emit) begin
                        main_load = 1'b1;
                    end else if (emit) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (emit) begin
                        state_nxt      = ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_entry;

    ex_mem_entry_reg #(.W(W)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    ex_mem_entry_reg #(.W(W)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .d     (in_entry),
        .q     (skid_q)
    );

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: queue-model scoreboard plus directed checks for ex_mem_stage.
`default_nettype none

module tb_ex_mem_stage;
    import ex_mem_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         alu_zero = 1'b0;
    logic [63:0]  alu_result = '0;
    logic [63:0]  wr_data = '0;
    logic [4:0]   rd = '0;
    ex_mem_ctrl_t ctrl = '0;
    logic         in_ready, out_valid, out_zero;
    logic [63:0]  out_result, out_wr_data;
    logic [4:0]   out_rd;
    ex_mem_ctrl_t out_ctrl;
`ifdef EX_MEM_BRANCH_RESOLVE_EN
    logic [63:0]  br_target = '0;
    logic [63:0]  out_br_target;
    logic         out_pcsrc;
`endif

    ex_mem_stage #(.N(64), .RW(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .wr_data     (wr_data),
        .rd          (rd),
        .ctrl        (ctrl),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_wr_data (out_wr_data),
        .out_rd      (out_rd),
        .out_ctrl    (out_ctrl)
`ifdef EX_MEM_BRANCH_RESOLVE_EN
       ,.br_target     (br_target),
        .out_pcsrc     (out_pcsrc),
        .out_br_target (out_br_target)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]  res;
        logic         z;
        logic [63:0]  wd;
        logic [4:0]   rd;
        ex_mem_ctrl_t c;
        logic [63:0]  bt;
    } ent_t;

    ent_t model[$];
    int   tests = 0;
    int   fails = 0;
    int   n_emit_dut = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an ordered queue of at most two entries, checked every cycle.
    always @(posedge clk) begin
        ent_t e;
        bit   m_emit, m_acc;
        e.res = alu_result;
        e.z   = alu_zero;
        e.wd  = wr_data;
        e.rd  = rd;
        e.c   = ctrl;
`ifdef EX_MEM_BRANCH_RESOLVE_EN
        e.bt  = br_target;
`else
        e.bt  = '0;
`endif
        if (out_valid && out_ready && reset && !flush) n_emit_dut++;
        if (!reset || flush) begin
            model.delete();
        end else begin
            m_emit = (model.size() != 0) && out_ready;
            m_acc  = in_valid && (model.size() < 2);
            if (m_emit) void'(model.pop_front());
            if (m_acc) model.push_back(e);
        end
        #1;
        chk("m_in_ready", in_ready, (model.size() < 2));
        chk("m_out_valid", out_valid, (model.size() != 0));
        if (model.size() != 0) begin
            chk("m_result", out_result, model[0].res);
            chk("m_zero", out_zero, model[0].z);
            chk("m_wr_data", out_wr_data, model[0].wd);
            chk("m_rd", out_rd, model[0].rd);
            chk("m_ctrl", out_ctrl, model[0].c);
`ifdef EX_MEM_BRANCH_RESOLVE_EN
            chk("m_br_target", out_br_target, model[0].bt);
            chk("m_pcsrc", out_pcsrc, model[0].c.branch & model[0].z);
`endif
        end else if (!reset) begin
            chk("m_rst_result", out_result, 64'h0);
            chk("m_rst_ctrl", out_ctrl, 64'h0);
`ifdef EX_MEM_BRANCH_RESOLVE_EN
            chk("m_rst_pcsrc", out_pcsrc, 64'h0);
`endif
        end
`ifdef EX_MEM_BRANCH_RESOLVE_EN
        else begin
            chk("m_idle_pcsrc", out_pcsrc, 64'h0);
        end
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input logic v, input logic [63:0] r, input logic z);
        in_valid   = v;
        alu_result = r;
        alu_zero   = z;
        wr_data    = ~r;
        rd         = r[4:0];
        ctrl       = ex_mem_ctrl_t'(r[9:5]);
    endtask

    initial begin
        int base, acc, cycles;

        // Reset held with a valid input present
        put(1'b1, 64'h77, 1'b0);
        out_ready = 1'b1;
        repeat (2) cyc();
        chk("rst_out_valid", out_valid, 64'h0);
        chk("rst_out_result", out_result, 64'h0);
        put(1'b0, 64'h0, 1'b0);
        reset = 1'b1;
        cyc();
        chk("rel_in_ready", in_ready, 64'h1);
        chk("rel_out_valid", out_valid, 64'h0);

        // Back-to-back streaming, one entry per cycle
        put(1'b1, 64'h5, 1'b0);
        cyc();
        chk("str0_result", out_result, 64'h5);
        chk("str0_zero", out_zero, 64'h0);
        put(1'b1, 64'h0, 1'b1);
        cyc();
        chk("str1_result", out_result, 64'h0);
        chk("str1_zero", out_zero, 64'h1);
        put(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        cyc();
        chk("str2_result", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("str2_zero", out_zero, 64'h0);
        // Zero flag is carried as given, not derived from the result
        put(1'b1, 64'h7, 1'b1);
        cyc();
        chk("zero_passthru", out_zero, 64'h1);
        put(1'b0, 64'h0, 1'b0);
        cyc();
        chk("str_drained", out_valid, 64'h0);

        // Backpressure fills both entries
        out_ready = 1'b0;
        put(1'b1, 64'h10, 1'b0);
        cyc();
        put(1'b1, 64'h20, 1'b0);
        cyc();
        chk("bp_in_ready", in_ready, 64'h0);
        chk("bp_hold_a", out_result, 64'h10);
        put(1'b1, 64'h99, 1'b0);
        cyc();
        chk("bp_stable_a", out_result, 64'h10);
        put(1'b0, 64'h0, 1'b0);
        out_ready = 1'b1;
        cyc();
        chk("bp_then_b", out_result, 64'h20);
        chk("bp_b_valid", out_valid, 64'h1);
        cyc();
        chk("bp_empty", out_valid, 64'h0);

        // Flush while full with a same-cycle input
        out_ready = 1'b0;
        put(1'b1, 64'h1, 1'b0);
        cyc();
        put(1'b1, 64'h2, 1'b0);
        cyc();
        put(1'b1, 64'h30, 1'b0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("fl_out_valid", out_valid, 64'h0);
        chk("fl_in_ready", in_ready, 64'h1);
        put(1'b0, 64'h0, 1'b0);
        out_ready = 1'b1;
        repeat (3) begin
            cyc();
            chk("fl_no_emit", out_valid, 64'h0);
        end

`ifdef EX_MEM_BRANCH_RESOLVE_EN
        put(1'b1, 64'h0, 1'b1);
        ctrl      = '0;
        ctrl.branch = 1'b1;
        br_target = 64'h400;
        cyc();
        chk("br_taken_pcsrc", out_pcsrc, 64'h1);
        chk("br_target", out_br_target, 64'h400);
        put(1'b1, 64'h5, 1'b0);
        ctrl      = '0;
        ctrl.branch = 1'b1;
        cyc();
        chk("br_nt_pcsrc", out_pcsrc, 64'h0);
        put(1'b0, 64'h0, 1'b0);
        br_target = '0;
        cyc();
`endif

        // Reset asserted with two entries held
        out_ready = 1'b0;
        put(1'b1, 64'hA, 1'b0);
        cyc();
        put(1'b1, 64'hB, 1'b0);
        cyc();
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 64'h0);
        chk("mid_rst_result", out_result, 64'h0);
        put(1'b0, 64'h0, 1'b0);
        cyc();
        reset = 1'b1;
        out_ready = 1'b1;
        cyc();
        chk("mid_rst_release", out_valid, 64'h0);

        // Random valid/ready traffic
        base   = n_emit_dut;
        acc    = 0;
        cycles = 0;
        while (acc < 1000 && cycles < 20000) begin
            put(($urandom_range(0, 3) != 0), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) acc++;
            cyc();
            cycles++;
        end
        chk("rand_accepted", acc, 1000);
        put(1'b0, 64'h0, 1'b0);
        out_ready = 1'b1;
        repeat (4) cyc();
        chk("rand_emit_count", n_emit_dut - base, acc);
        chk("rand_drained", model.size(), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
